// File: rtl/mem_port_arbiter.sv
// Arbitrates one pipelined single-port RAM between instruction fetch and data access.
// Data has fixed priority; a saturating starvation counter forces a fetch grant.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rstn,
    input  logic              i_iReq,
    input  logic [ADDR_W-1:0] i_iAddr,
    output logic              o_iGnt,
    output logic              o_iValid,
    output logic [DATA_W-1:0] o_iData,
    input  logic              i_dReadEn,
    input  logic              i_dWriteEn,
    input  logic [ADDR_W-1:0] i_dAddr,
    input  logic [DATA_W-1:0] i_dWData,
    output logic              o_dGnt,
    output logic              o_dValid,
    output logic [DATA_W-1:0] o_dRData,
    output logic              o_Mem_En,
    output logic              o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_WData,
    input  logic [DATA_W-1:0] i_Mem_RData
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    owner_e            owner_q, owner_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] i_hold_q, i_hold_d;
    logic [DATA_W-1:0] d_hold_q, d_hold_d;
    logic              d_req;
    logic              fetch_force;
    logic              i_gnt;
    logic              d_gnt;

    // Grant selection and memory command drive; depends only on requests and counter.
    always_comb begin
        d_req       = i_dReadEn | i_dWriteEn;
        fetch_force = (starve_cnt_q == STARVE_MAX_C);
        d_gnt       = d_req & ~(i_iReq & fetch_force);
        i_gnt       = i_iReq & ~d_gnt;
        o_iGnt      = i_gnt;
        o_dGnt      = d_gnt;
        o_Mem_En    = i_gnt | d_gnt;
        o_Mem_We    = 1'b0;
        o_Mem_Addr  = '0;
        o_Mem_WData = '0;
        if (d_gnt) begin
            o_Mem_Addr = i_dAddr;
            if (i_dWriteEn) begin
                o_Mem_We    = 1'b1;
                o_Mem_WData = i_dWData;
            end else begin
                o_Mem_We    = 1'b0;
                o_Mem_WData = '0;
            end
        end else if (i_gnt) begin
            o_Mem_Addr = i_iAddr;
        end else begin
            o_Mem_Addr = '0;
        end
    end

    // Next-state: starvation counter, read owner and per-port hold registers.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        owner_d      = OWN_NONE;
        i_hold_d     = i_hold_q;
        d_hold_d     = d_hold_q;
        if (i_gnt || !i_iReq) begin
            starve_cnt_d = 4'd0;
        end else if (d_gnt && starve_cnt_q != STARVE_MAX_C) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
        // A read+write data request is a write and produces no return.
        if (i_gnt) begin
            owner_d = OWN_I;
        end else if (d_gnt && !i_dWriteEn) begin
            owner_d = OWN_D;
        end else begin
            owner_d = OWN_NONE;
        end
        case (owner_q)
            OWN_I:   i_hold_d = i_Mem_RData;
            OWN_D:   d_hold_d = i_Mem_RData;
            default: begin
                i_hold_d = i_hold_q;
                d_hold_d = d_hold_q;
            end
        endcase
    end

    // State registers; reset discards any read still in flight.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= 4'd0;
            i_hold_q     <= '0;
            d_hold_q     <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            i_hold_q     <= i_hold_d;
            d_hold_q     <= d_hold_d;
        end
    end

    // Return path: pass memory data through in the valid cycle, else show the hold value.
    always_comb begin
        o_iValid = (owner_q == OWN_I);
        o_dValid = (owner_q == OWN_D);
        if (o_iValid) begin
            o_iData = i_Mem_RData;
        end else begin
            o_iData = i_hold_q;
        end
        if (o_dValid) begin
            o_dRData = i_Mem_RData;
        end else begin
            o_dRData = d_hold_q;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction fetch bus (IBUS) and its data bus (DBUS).
- Sits between Core_STR and a unified memory, so one RAM holds both code and data.
- Data accesses have fixed priority. A starvation counter guarantees forward progress on fetch.
- The memory is pipelined: it accepts one command per cycle and returns read data on the cycle after the command.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data bus width.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending before fetch is forced to win; legal range 1..15.

Ports:
- i_Clk  in  1  system clock; all state updates on the rising edge.
- i_Rstn  in  1  reset, asynchronous, active-low.
- i_iReq  in  1  instruction fetch request.
- i_iAddr  in  ADDR_W  fetch address.
- o_iGnt  out  1  fetch accepted this cycle.
- o_iValid  out  1  fetch data valid.
- o_iData  out  DATA_W  fetch data.
- i_dReadEn  in  1  data read request.
- i_dWriteEn  in  1  data write request.
- i_dAddr  in  ADDR_W  data address.
- i_dWData  in  DATA_W  write data.
- o_dGnt  out  1  data access accepted this cycle.
- o_dValid  out  1  data read data valid.
- o_dRData  out  DATA_W  data read data.
- o_Mem_En  out  1  memory command strobe.
- o_Mem_We  out  1  memory write enable.
- o_Mem_Addr  out  ADDR_W  memory address.
- o_Mem_WData  out  DATA_W  memory write data.
- i_Mem_RData  in  DATA_W  memory read data, valid the cycle after a read command.

Behaviour:
- Clock/reset: one clock, i_Clk. Reset i_Rstn is asynchronous, active-low.
- Reset values:
  - o_iValid, o_dValid = 0.
  - Hold registers = 0, so o_iData and o_dRData read 0.
  - Starvation counter = 0; outstanding-owner register = NONE.
- Request handshake: a requester keeps its request, address and write data stable until it sees its grant.
- Grant logic: o_iGnt, o_dGnt and the o_Mem_* outputs are combinational from the requests and the counter.
  - At most one grant per cycle.
  - o_Mem_En = o_iGnt | o_dGnt.
  - While no grant is given, o_Mem_* are all 0.
- Arbitration, evaluated every cycle:
  - Data only: data wins.
  - Fetch only: fetch wins.
  - Both requesting: data wins, unless counter == STARVE_MAX, in which case fetch wins.
- Starvation counter:
  - Increments when data is granted while i_iReq = 1.
  - Clears to 0 when fetch is granted or i_iReq = 0.
  - Saturates at STARVE_MAX.
- Data read and write both asserted: handled as a write only. No o_dValid follows.
- Write grant:
  - o_Mem_We = 1; o_Mem_WData = i_dWData; o_Mem_Addr = i_dAddr.
  - Completes in the grant cycle; no valid pulse.
- Read grant:
  - o_Mem_We = 0; address comes from the winner.
  - The owner register records I or D.
- Read return, the cycle after a read grant:
  - The owner's valid goes high for exactly 1 cycle.
  - Its data output is i_Mem_RData passed through in that cycle.
  - The same value is captured into that port's hold register.
  - Outside valid cycles, o_iData / o_dRData present the hold register (last value returned).
- Pipelining:
  - A new grant may issue in the same cycle a previous read returns.
  - Back-to-back reads give one valid per cycle, in grant order.
  - Throughput is 1 access/cycle.
- Reset mid-operation: an outstanding read is discarded and no valid follows after reset release. Counter and owner clear immediately.
- No combinational path from i_Mem_RData to any grant or memory output.

Test Plan:
- Reset, then fetch only (i_iReq=1, addr 0x10; memory returns 0xDEADBEEF) -> o_iGnt=1 in cycle 0; o_iValid=1 with o_iData=0xDEADBEEF in cycle 1; o_dValid stays 0.
- Simultaneous i_iReq and i_dReadEn, both held -> grants D, D, D, D, then I on the 5th cycle (STARVE_MAX=4); counter reads 0 after the I grant.
- Data write (addr 0x20, data 0x12345678) together with a fetch -> o_dGnt=1, o_Mem_We=1, o_Mem_WData=0x12345678 in cycle 0; no o_dValid; fetch granted in cycle 1.
- Alternating back-to-back reads (I@0x0, D@0x4, I@0x8) -> o_Mem_En=1 for 3 consecutive cycles; valids I, D, I in the next 3 cycles; data correctly routed; o_iData holds the 0x8 data afterwards.
- i_dReadEn and i_dWriteEn both high at addr 0x30 -> treated as a write (o_Mem_We=1); o_dValid never pulses.
- Read granted, then i_Rstn low before the return cycle -> all valids 0; o_iData = o_dRData = 0; no valid after reset release.
